// File: rtl/equation_checker.sv
// Serial-entry N x N linear-system checker.
// Captures A, b and x on Go edges, then verifies A*x == b with one MAC per cycle.
module equation_checker #(
  parameter int N     = 3,
  parameter int W     = 4,
  parameter int ACC_W = 2*W+3
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Go,
  input  logic         start,
  input  logic         retry,
  input  logic [W-1:0] data_in,
  output logic         busy,
  output logic [1:0]   load_phase,
  output logic [3:0]   load_idx,
  output logic         done,
  output logic         correct
);

  localparam int NN = N*N;
  localparam int AW = (NN > 4) ? 4 : 2;
  localparam int CW = (N > 2) ? 2 : 1;
  localparam int RW = (N > 3) ? 3 : 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_X,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic                go_q, go_d;
  logic [3:0]          idx_q, idx_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                mis_q, mis_d;
  logic [W-1:0]        a_q [NN];
  logic [W-1:0]        a_d [NN];
  logic [W-1:0]        b_q [N];
  logic [W-1:0]        b_d [N];
  logic [W-1:0]        x_q [N];
  logic [W-1:0]        x_d [N];

  logic                cap;
  logic                last_a;
  logic                last_n;
  logic                mac_end;
  logic [AW-1:0]       aidx;
  logic [W-1:0]        a_cur;
  logic [W-1:0]        x_cur;
  logic [W-1:0]        b_cur;
  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] x_ext;
  logic signed [2*W-1:0] prod;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    b_ext;

  assign cap     = Go & ~go_q;
  assign last_a  = (idx_q == 4'(NN-1));
  assign last_n  = (idx_q == 4'(N-1));
  assign mac_end = (row_q == RW'(N));

  // State register plus all datapath flops, cleared synchronously
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      mis_q   <= 1'b0;
      for (int i = 0; i < NN; i++) a_q[i] <= '0;
      for (int i = 0; i < N; i++) begin
        b_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      mis_q   <= mis_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
    end
  end

  // Next-state: loads advance on the last capture, COMPUTE exits after all rows
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD_A;
      S_LOAD_A:  if (cap && last_a) state_d = S_LOAD_B;
      S_LOAD_B:  if (cap && last_n) state_d = S_LOAD_X;
      S_LOAD_X:  if (cap && last_n) state_d = S_COMPUTE;
      S_COMPUTE: if (mac_end) state_d = S_DONE;
      S_DONE: begin
        if (start)      state_d = S_LOAD_A;
        else if (retry) state_d = S_LOAD_X;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Current MAC operands, sign-extended so products and sums are exact
  always_comb begin
    aidx  = AW'(int'(row_q) * N + int'(col_q));
    a_cur = a_q[aidx];
    x_cur = x_q[col_q];
    b_cur = b_q[row_q[CW-1:0]];
    a_ext = {{W{a_cur[W-1]}}, a_cur};
    x_ext = {{W{x_cur[W-1]}}, x_cur};
    prod  = a_ext * x_ext;
    sum   = acc_q + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    b_ext = {{(ACC_W-W){b_cur[W-1]}}, b_cur};
  end

  // Word capture, index tracking and the row-by-row accumulate/compare
  always_comb begin
    go_d  = Go;
    idx_d = idx_q;
    row_d = row_q;
    col_d = col_q;
    acc_d = acc_q;
    mis_d = mis_q;
    a_d   = a_q;
    b_d   = b_q;
    x_d   = x_q;
    unique case (state_q)
      S_LOAD_A: begin
        if (cap) begin
          a_d[idx_q[AW-1:0]] = data_in;
          idx_d = last_a ? 4'd0 : idx_q + 4'd1;
        end
      end
      S_LOAD_B: begin
        if (cap) begin
          b_d[idx_q[CW-1:0]] = data_in;
          idx_d = last_n ? 4'd0 : idx_q + 4'd1;
        end
      end
      S_LOAD_X: begin
        if (cap) begin
          x_d[idx_q[CW-1:0]] = data_in;
          idx_d = last_n ? 4'd0 : idx_q + 4'd1;
          if (last_n) begin
            row_d = '0;
            col_d = '0;
            acc_d = '0;
            mis_d = 1'b0;
          end
        end
      end
      S_COMPUTE: begin
        if (!mac_end) begin
          if (col_q == CW'(N-1)) begin
            if (sum != b_ext) mis_d = 1'b1;
            acc_d = '0;
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            acc_d = sum;
            col_d = col_q + CW'(1);
          end
        end
      end
      default: idx_d = '0;
    endcase
  end

  // Outputs decoded from state and registered flags only
  always_comb begin
    busy       = 1'b0;
    load_phase = 2'd3;
    done       = 1'b0;
    unique case (state_q)
      S_LOAD_A:  begin busy = 1'b1; load_phase = 2'd0; end
      S_LOAD_B:  begin busy = 1'b1; load_phase = 2'd1; end
      S_LOAD_X:  begin busy = 1'b1; load_phase = 2'd2; end
      S_COMPUTE: busy = 1'b1;
      S_DONE:    done = 1'b1;
      default:   busy = 1'b0;
    endcase
    load_idx = idx_q;
    correct  = done & ~mis_q;
  end

endmodule

// File: tb/tb_equation_checker.sv
// Bench for equation_checker: N=3 and N=2 instances, table vectors
// plus hand sequences, expected results queued and popped on done.
`timescale 1ns/1ps
module tb_equation_checker;

  logic       Clock = 0;
  logic       Reset = 1;
  logic       go3 = 0, start3 = 0, retry3 = 0;
  logic [3:0] data3 = 0;
  logic       busy3, done3, correct3;
  logic [1:0] phase3;
  logic [3:0] idx3;
  logic       go2 = 0, start2 = 0, retry2 = 0;
  logic [3:0] data2 = 0;
  logic       busy2, done2, correct2;
  logic [1:0] phase2;
  logic [3:0] idx2;

  always #5 Clock = ~Clock;

  equation_checker #(.N(3), .W(4)) u3 (
    .Clock(Clock), .Reset(Reset), .Go(go3), .start(start3),
    .retry(retry3), .data_in(data3), .busy(busy3),
    .load_phase(phase3), .load_idx(idx3), .done(done3),
    .correct(correct3)
  );

  equation_checker #(.N(2), .W(4)) u2 (
    .Clock(Clock), .Reset(Reset), .Go(go2), .start(start2),
    .retry(retry2), .data_in(data2), .busy(busy2),
    .load_phase(phase2), .load_idx(idx2), .done(done2),
    .correct(correct2)
  );

  typedef struct {
    int a [16];
    int b [4];
    int x [4];
    int exp_ok;
  } vec_t;

  vec_t tbl [4];
  int   sb_q [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_go(input bit sel, input logic v, input int w);
    if (sel) begin go2 = v; data2 = 4'(w); end
    else     begin go3 = v; data3 = 4'(w); end
  endtask

  task automatic pulse(input bit sel, input int w);
    set_go(sel, 1'b1, w);
    step();
    set_go(sel, 1'b0, w);
    step();
  endtask

  function automatic int dn(input bit sel);
    return sel ? int'(done2) : int'(done3);
  endfunction

  function automatic int ok(input bit sel);
    return sel ? int'(correct2) : int'(correct3);
  endfunction

  // lat0: edges already elapsed since the final x capture
  task automatic wait_done(input bit sel, input int lat0, input int exp_lat);
    int lat;
    int e;
    lat = lat0;
    while (dn(sel) == 0 && lat < 60) begin
      step();
      lat++;
    end
    if (dn(sel) == 0) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("latency", lat, exp_lat);
    e = sb_q.pop_front();
    chk("correct", ok(sel), e);
  endtask

  task automatic do_start(input bit sel);
    if (sel) start2 = 1; else start3 = 1;
    step();
    if (sel) start2 = 0; else start3 = 0;
  endtask

  task automatic load_ab(input bit sel, input vec_t v, input int from);
    int n;
    n = sel ? 2 : 3;
    for (int i = from; i < n*n; i++) pulse(sel, v.a[i]);
    for (int i = 0; i < n; i++) pulse(sel, v.b[i]);
  endtask

  task automatic load_x(input bit sel, input vec_t v);
    int n;
    n = sel ? 2 : 3;
    for (int i = 0; i < n; i++) pulse(sel, v.x[i]);
    sb_q.push_back(v.exp_ok);
  endtask

  vec_t v;

  initial begin
    tbl[0].a = '{1,2,0, 0,1,1, 1,0,1, 0,0,0,0,0,0,0};
    tbl[0].b = '{3,3,3,0};
    tbl[0].x = '{1,1,2,0};
    tbl[0].exp_ok = 1;
    tbl[1].a = '{-8,-8,-8, -8,-8,-8, -8,-8,-8, 0,0,0,0,0,0,0};
    tbl[1].b = '{0,0,0,0};
    tbl[1].x = '{-8,-8,-8,0};
    tbl[1].exp_ok = 0;
    tbl[2].a = '{-1,2,3, 4,-5,0, 0,0,1, 0,0,0,0,0,0,0};
    tbl[2].b = '{4,-1,1,0};
    tbl[2].x = '{1,1,1,0};
    tbl[2].exp_ok = 1;
    tbl[3].a = '{1,2,0, 0,1,1, 1,0,1, 0,0,0,0,0,0,0};
    tbl[3].b = '{3,3,3,0};
    tbl[3].x = '{1,1,1,0};
    tbl[3].exp_ok = 0;

    step();
    step();
    chk("rst_busy", busy3, 0);
    chk("rst_done", done3, 0);
    chk("rst_correct", correct3, 0);
    chk("rst_phase", phase3, 3);
    chk("rst_idx", idx3, 0);
    Reset = 0;
    step();

    retry2 = 1;
    step();
    retry2 = 0;
    chk("retry_idle_phase", phase2, 3);

    for (int k = 0; k < 4; k++) begin
      do_start(1'b0);
      chk("start_busy", busy3, 1);
      chk("start_phase", phase3, 0);
      load_ab(1'b0, tbl[k], 0);
      chk("x_phase", phase3, 2);
      load_x(1'b0, tbl[k]);
      wait_done(1'b0, 1, 10);
    end

    retry3 = 1;
    step();
    retry3 = 0;
    chk("retry_phase", phase3, 2);
    chk("retry_done", done3, 0);
    v = tbl[0];
    load_x(1'b0, v);
    wait_done(1'b0, 1, 10);

    do_start(1'b0);
    set_go(1'b0, 1'b1, v.a[0]);
    repeat (5) step();
    set_go(1'b0, 1'b0, 0);
    step();
    chk("go_hold_idx", idx3, 1);
    load_ab(1'b0, v, 1);
    load_x(1'b0, v);
    pulse(1'b0, 7);
    pulse(1'b0, 7);
    chk("go_in_compute_busy", busy3, 1);
    wait_done(1'b0, 5, 10);

    do_start(1'b0);
    load_ab(1'b0, v, 0);
    for (int i = 0; i < 3; i++) pulse(1'b0, v.x[i]);
    step();
    Reset = 1;
    step();
    Reset = 0;
    chk("midrst_busy", busy3, 0);
    chk("midrst_done", done3, 0);
    chk("midrst_correct", correct3, 0);
    chk("midrst_phase", phase3, 3);
    do_start(1'b0);
    load_ab(1'b0, v, 0);
    load_x(1'b0, v);
    wait_done(1'b0, 1, 10);

    v.a = '{2,-1,1,1, 0,0,0,0,0,0,0,0,0,0,0,0};
    v.b = '{1,5,0,0};
    v.x = '{2,3,0,0};
    v.exp_ok = 1;
    do_start(1'b1);
    load_ab(1'b1, v, 0);
    load_x(1'b1, v);
    wait_done(1'b1, 1, 5);
    start2 = 1;
    retry2 = 1;
    step();
    start2 = 0;
    retry2 = 0;
    chk("n2_both_phase", phase2, 0);
    chk("n2_both_done", done2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/equation_checker.md
# equation_checker

Parametrised linear-system answer checker for the alarm puzzle flow. The player serially enters an N×N signed coefficient matrix A, a right-hand vector b and a candidate solution x; the block computes A·x row by row with one multiply-accumulate per cycle and asserts `correct` only if every row equals b exactly. It sits behind the equation generators and drives the dismiss/retry logic. Unlike the fixed 3×3 elimination datapath, it is generic in N and W, accepts user input and checks it, and supports re-entering x without reloading A and b.

## Interface
- N, 3, system order; legal range 2..4
- W, 4, data word width; signed two's complement
- ACC_W, 2*W+3, accumulator width; derived, do not override
- Clock  input  1  system clock, all state on rising edge
- Reset  input  1  synchronous, active-high reset
- Go  input  1  player "enter" key; one word is captured per rising edge of Go
- start  input  1  begin a new puzzle; honoured only in IDLE or DONE
- retry  input  1  re-enter x only; honoured only in DONE
- data_in  input  W  word presented with Go
- busy  output  1  high in LOAD_A, LOAD_B, LOAD_X and COMPUTE
- load_phase  output  2  0=A, 1=b, 2=x, 3=not loading
- load_idx  output  4  index of the next word to capture within the current phase
- done  output  1  high while in DONE
- correct  output  1  high in DONE iff all N rows matched

## Operation
- States: IDLE, LOAD_A, LOAD_B, LOAD_X, COMPUTE, DONE.
- Go edge detect: a capture event occurs when Go=1 at the current edge and Go was 0 at the previous edge (registered copy). Holding Go high gives exactly one capture.
- IDLE: start -> LOAD_A. Go is ignored, but the edge register still tracks it.
- LOAD_A: N*N captures, row-major (A[r][c], load_idx = r*N+c). On the last capture -> LOAD_B.
- LOAD_B: N captures into b[0..N-1]. On the last capture -> LOAD_X.
- LOAD_X: N captures into x[0..N-1]. On the last capture -> COMPUTE; the accumulator, column/row counters and mismatch flag clear.
- COMPUTE: one cycle per (r,c): acc += sext(A[r][c]) * sext(x[c]). At c=N-1 the final sum is compared to sext(b[r]). Any inequality sets the sticky `mismatch` flag, then acc clears for the next row. After N*N cycles -> DONE.
- Arithmetic: products are exact 2W-bit signed values, and sums are exact in ACC_W. There is no wrap or saturation, so a sum outside the W-bit range can never equal b.
- DONE: done=1; correct = ~mismatch. start -> LOAD_A, which discards all stored data on overwrite. retry -> LOAD_X, keeping A and b. If start and retry are both high, start wins. Go is ignored.
- start in LOAD_*/COMPUTE, and retry outside DONE, are ignored.
- A capture event is consumed only in LOAD_* states. A Go edge arriving in the same cycle as a state change out of LOAD_* is not carried over.

## Timing
- Reset (any state, including mid-load or mid-COMPUTE): state=IDLE. All outputs go to 0, except load_phase=3. All counters, acc, mismatch, the Go edge register, A, b and x clear to 0.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs.
- The capture takes effect at the clock edge where the event is sampled. load_idx advances on that same edge.
- Final x capture at edge t: COMPUTE occupies edges t+1..t+N*N, and done/correct rise after edge t+N*N+1 (latency N*N+1; 10 cycles for N=3).
- start/retry accepted at edge t: busy=1 after edge t, and done drops to 0 after the same edge.
- Throughput: fixed COMPUTE length of N*N cycles, independent of data and with no early exit.

## Test plan
- N=3, W=4: A=[[1,2,0],[0,1,1],[1,0,1]], b=[3,3,3], x=[1,1,2] -> done=1, correct=1 exactly 10 cycles after the last x capture.
- Same A and b, x=[1,1,1] (A·x=[3,2,2]) -> correct=0. Then retry with x=[1,1,2] -> correct=1, with no A/b reload and only 3 Go edges needed.
- Width check: every A entry = -8, every x entry = -8 (row sum 192), b=[0,0,0] -> correct=0 (192 mod 16 = 0 must not alias).
- Go held high for 5 cycles during LOAD_A -> load_idx advances by exactly 1. Go pulses during COMPUTE -> no state or data change.
- Reset asserted mid-COMPUTE -> next cycle state=IDLE, busy/done/correct=0, load_phase=3. A new start plus a full reload of the first scenario's values -> correct=1.
- N=2 build: A=[[2,-1],[1,1]], b=[1,5], x=[2,3] -> correct=1 at latency 5. In DONE, start and retry asserted together -> load_phase=0 (start wins).
